// File: rtl/data_sram_ctrl_pkg.sv
// Shared state encodings, bus size codes and constants for the data-side sram controller.
// Optional timeout support is selected with the MEMCTRL_TIMEOUT_EN macro.
package data_sram_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;
  localparam logic [1:0]  SZ_WORD = 2'b10;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // A bus transaction is outstanding in these states
  function automatic logic in_flight(state_t s);
    return (s == S_ADDR) || (s == S_DATA);
  endfunction

endpackage

// File: rtl/data_sram_ctrl_timer.sv
// Transaction watchdog: counts cycles a bus access is outstanding and flags expiry.
// Compiled only when MEMCTRL_TIMEOUT_EN is defined.
`ifdef MEMCTRL_TIMEOUT_EN
module data_sram_ctrl_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + CW'(1);
  end

  // Fires on the last permitted outstanding cycle so the error lands exactly TIMEOUT_CYCLES later
  assign hit = en && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/data_sram_ctrl.sv
// MEM-stage load/store sequencer for the sram-like data bus; stalls the pipe until completion.
// MEMCTRL_TIMEOUT_EN adds a watchdog with a bus_err pulse and poisoned read data.
module data_sram_ctrl
  import data_sram_ctrl_pkg::*;
`ifdef MEMCTRL_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_wen,
  input  logic [3:0]  mem_sel,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        stall_other,
  input  logic        flush,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall
`ifdef MEMCTRL_TIMEOUT_EN
  ,
  output logic        bus_err
`endif
);

  state_t state, state_nxt;
  logic   flushed;
  logic   go;
  logic   timeout;

  assign go = (state == S_IDLE) && mem_en && !flush;

`ifdef MEMCTRL_TIMEOUT_EN
  data_sram_ctrl_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (go),
    .en  (in_flight(state)),
    .hit (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (go) state_nxt = S_ADDR;
      S_ADDR: begin
        if (data_addr_ok)
          state_nxt = S_DATA;
        else if (flush)
          state_nxt = S_IDLE;
        else if (timeout)
          state_nxt = S_DONE;
      end
      S_DATA: begin
        // A flushed access is drained but its result is never presented
        if (data_data_ok || timeout)
          state_nxt = (flushed || flush) ? S_IDLE : S_DONE;
      end
      S_DONE: if (!stall_other || flush) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_stall = go || in_flight(state);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= 2'b00;
      data_addr  <= '0;
      data_wdata <= '0;
      data_wstrb <= '0;
      mem_rdata  <= '0;
      flushed    <= 1'b0;
`ifdef MEMCTRL_TIMEOUT_EN
      bus_err    <= 1'b0;
`endif
    end else begin
`ifdef MEMCTRL_TIMEOUT_EN
      bus_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (go) begin
            data_req   <= 1'b1;
            data_wr    <= mem_wen;
            data_size  <= mem_size;
            data_addr  <= mem_addr;
            data_wdata <= mem_wdata;
            data_wstrb <= mem_sel;
          end
        end
        S_ADDR: begin
          if (data_addr_ok) begin
            data_req <= 1'b0;
            if (flush) flushed <= 1'b1;
          end else if (flush) begin
            data_req <= 1'b0;
          end else if (timeout) begin
            data_req  <= 1'b0;
            mem_rdata <= TIMEOUT_RDATA;
`ifdef MEMCTRL_TIMEOUT_EN
            bus_err   <= 1'b1;
`endif
          end
        end
        S_DATA: begin
          if (data_data_ok) begin
            if (!data_wr) mem_rdata <= data_rdata;
            flushed <= 1'b0;
          end else if (timeout) begin
            mem_rdata <= TIMEOUT_RDATA;
            flushed   <= 1'b0;
`ifdef MEMCTRL_TIMEOUT_EN
            bus_err   <= 1'b1;
`endif
          end else if (flush) begin
            flushed <= 1'b1;
          end
        end
        S_DONE: flushed <= 1'b0;
        default: flushed <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Directed bench for data_sram_ctrl: load/store sequencing, held completion, flushes, optional timeout.
module tb_data_sram_ctrl;
  import data_sram_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en, mem_wen, stall_other, flush;
  logic [3:0]  mem_sel;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] mem_rdata;
  logic        mem_stall;
`ifdef MEMCTRL_TIMEOUT_EN
  logic        bus_err;
`endif

  always #5 clk = ~clk;

`ifdef MEMCTRL_TIMEOUT_EN
  data_sram_ctrl #(.TIMEOUT_CYCLES(8)) dut (
`else
  data_sram_ctrl dut (
`endif
    .clk          (clk),
    .rst          (rst),
    .mem_en       (mem_en),
    .mem_wen      (mem_wen),
    .mem_sel      (mem_sel),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .stall_other  (stall_other),
    .flush        (flush),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_wstrb   (data_wstrb),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_rdata    (mem_rdata),
    .mem_stall    (mem_stall)
`ifdef MEMCTRL_TIMEOUT_EN
    ,
    .bus_err      (bus_err)
`endif
  );

  int nchk = 0;
  int nerr = 0;
  int req_cyc = 0;
  int acc_cnt = 0;
  logic [31:0] exp_q[$];

  always @(posedge clk) begin
    if (data_req) req_cyc <= req_cyc + 1;
    if (data_req && data_addr_ok) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wen, input logic [3:0] sel, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    mem_en    = 1'b1;
    mem_wen   = wen;
    mem_sel   = sel;
    mem_size  = size;
    mem_addr  = addr;
    mem_wdata = wdata;
  endtask

  task automatic pop_chk(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, mem_rdata, e);
    end
  endtask

  int r0, a0;

  initial begin
    rst = 1'b1; mem_en = 1'b0; mem_wen = 1'b0; mem_sel = 4'h0; mem_size = 2'b00;
    mem_addr = '0; mem_wdata = '0; stall_other = 1'b0; flush = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_addr", data_addr, 32'd0);
    chk("rst_wstrb", 32'(data_wstrb), 32'd0);

    // Minimum-latency word load
    r0 = req_cyc;
    issue(1'b0, 4'hF, SZ_WORD, 32'h8000_0010, 32'h0);
    exp_q.push_back(32'h1234_5678);
    #1 chk("ld_stall_t0", 32'(mem_stall), 32'd1);
    step();
    chk("ld_req_t1", 32'(data_req), 32'd1);
    chk("ld_addr_t1", data_addr, 32'h8000_0010);
    chk("ld_wr_t1", 32'(data_wr), 32'd0);
    chk("ld_size_t1", 32'(data_size), 32'(SZ_WORD));
    data_addr_ok = 1'b1;
    #1 chk("ld_stall_t1", 32'(mem_stall), 32'd1);
    step();
    data_addr_ok = 1'b0;
    chk("ld_req_t2", 32'(data_req), 32'd0);
    data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
    #1 chk("ld_stall_t2", 32'(mem_stall), 32'd1);
    step();
    data_data_ok = 1'b0; data_rdata = 32'h0;
    chk("ld_stall_t3", 32'(mem_stall), 32'd0);
    pop_chk("ld_rdata_t3");
    mem_en = 1'b0;
    step();
    chk("ld_req_cycles", 32'(req_cyc - r0), 32'd1);

    // Byte store with addr_ok held off for three cycles
    issue(1'b1, 4'b1000, SZ_BYTE, 32'h8000_0013, 32'hAB00_0000);
    exp_q.push_back(32'h1234_5678);
    step();
    for (int k = 0; k < 3; k++) begin
      chk("st_req_hold", 32'(data_req), 32'd1);
      chk("st_wstrb_hold", 32'(data_wstrb), 32'b1000);
      chk("st_wr_hold", 32'(data_wr), 32'd1);
      step();
    end
    chk("st_addr", data_addr, 32'h8000_0013);
    chk("st_wdata", data_wdata, 32'hAB00_0000);
    chk("st_req_before_ok", 32'(data_req), 32'd1);
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
    step();
    data_data_ok = 1'b0;
    chk("st_stall_done", 32'(mem_stall), 32'd0);
    pop_chk("st_rdata_kept");
    mem_en = 1'b0;
    step();

    // Completion held while the rest of the pipe is stalled
    r0 = req_cyc; a0 = acc_cnt;
    issue(1'b0, 4'hF, SZ_WORD, 32'h8000_0020, 32'h0);
    exp_q.push_back(32'hCAFE_F00D);
    step();
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D; stall_other = 1'b1;
    step();
    data_data_ok = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("hold_stall_low", 32'(mem_stall), 32'd0);
      chk("hold_req_low", 32'(data_req), 32'd0);
      step();
    end
    pop_chk("hold_rdata");
    stall_other = 1'b0;
    step();
    mem_en = 1'b0;
    step(); step();
    chk("hold_req_cycles", 32'(req_cyc - r0), 32'd1);
    chk("hold_accepts", 32'(acc_cnt - a0), 32'd1);

    // Flush before addr_ok withdraws the request; flush beats mem_en in idle
    issue(1'b0, 4'hF, SZ_WORD, 32'h8000_0030, 32'h0);
    step();
    chk("fa_req_t1", 32'(data_req), 32'd1);
    flush = 1'b1;
    step();
    chk("fa_req_dropped", 32'(data_req), 32'd0);
    #1 chk("fa_stall_low", 32'(mem_stall), 32'd0);
    flush = 1'b0; mem_en = 1'b0;
    step();
    chk("fa_still_idle", 32'(data_req), 32'd0);

    // Flush during the data phase: drained, rdata updated, back to idle
    issue(1'b0, 4'hF, SZ_WORD, 32'h8000_0040, 32'h0);
    exp_q.push_back(32'h5A5A_1111);
    step();
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0; flush = 1'b1; mem_en = 1'b0;
    step();
    flush = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h5A5A_1111;
    #1 chk("fd_stall_wait", 32'(mem_stall), 32'd1);
    step();
    data_data_ok = 1'b0;
    pop_chk("fd_rdata");
    // A parked S_DONE would not stall; a true idle starts the next access
    issue(1'b0, 4'hF, SZ_WORD, 32'h8000_0050, 32'h0);
    stall_other = 1'b1;
    #1 chk("fd_idle_not_done", 32'(mem_stall), 32'd1);
    step();
    stall_other = 1'b0;
    chk("fd_next_req", 32'(data_req), 32'd1);
    chk("fd_next_addr", data_addr, 32'h8000_0050);
    exp_q.push_back(32'h0BAD_CAFE);
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0BAD_CAFE;
    step();
    data_data_ok = 1'b0;
    pop_chk("fd_next_rdata");
    mem_en = 1'b0;
    step();

`ifdef MEMCTRL_TIMEOUT_EN
    // Bus never answers: watchdog fires after eight outstanding cycles
    issue(1'b0, 4'hF, SZ_WORD, 32'h8000_0060, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("to_no_err_yet", 32'(bus_err), 32'd0);
    end
    step();
    chk("to_bus_err", 32'(bus_err), 32'd1);
    chk("to_rdata", mem_rdata, 32'hDEAD_BEEF);
    chk("to_stall_low", 32'(mem_stall), 32'd0);
    mem_en = 1'b0;
    step();
    chk("to_err_pulse", 32'(bus_err), 32'd0);
`endif

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
